// File: rtl/vga_sync_receiver.sv
// VGA timing sink: recovers pixel coordinates from h_sync/v_sync/DE, measures
// line/frame geometry and runs a lock FSM that qualifies the incoming timing.
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        DE,
  output logic [9:0]  x_pixel,
  output logic [9:0]  y_pixel,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic [10:0] h_total_meas,
  output logic [9:0]  v_total_meas,
  output logic        locked,
  output logic        timing_err
);

  localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
  localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
  localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [10:0] TMO_C      = 11'(2 * H_TOTAL);
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} state_t;

  logic        hs_q, vs_q, de_q, hs_dly_q, vs_dly_q, de_dly_q;
  logic        hs_fall, vs_fall, de_rise, de_fall;
  logic [9:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [10:0] h_per_q, h_per_d, h_meas;
  logic [11:0] h_per_inc;
  logic [9:0]  v_lines_q, v_lines_eff;
  logic [10:0] de_len_q, de_len_d;
  logic [9:0]  de_lines_q, de_lines_eff;
  logic        frame_bad_q, bad_now, frame_good;
  logic        tmo_armed_q, tmo;
  state_t      state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        err_d;
  logic [9:0]  x_pixel_q, y_pixel_q, v_total_meas_q;
  logic [10:0] h_total_meas_q;
  logic        pixel_valid_q, frame_start_q, locked_q, timing_err_q;

  // Edges compare stage 1 against its one-clock-delayed copy (syncs are active low)
  assign hs_fall = hs_dly_q & ~hs_q;
  assign vs_fall = vs_dly_q & ~vs_q;
  assign de_rise = ~de_dly_q & de_q;
  assign de_fall = de_dly_q & ~de_q;

  assign h_per_inc    = {1'b0, h_per_q} + 12'd1;
  assign h_meas       = h_per_inc[11] ? 11'h7FF : h_per_inc[10:0];
  assign v_lines_eff  = (hs_fall && v_lines_q != 10'h3FF) ? v_lines_q + 10'd1 : v_lines_q;
  assign de_lines_eff = (de_fall && de_lines_q != 10'h3FF) ? de_lines_q + 10'd1 : de_lines_q;
  assign tmo          = tmo_armed_q && (h_per_q >= TMO_C);

  // A sync edge coinciding with vs_fall still belongs to the frame being judged
  assign bad_now    = (hs_fall && h_per_inc != H_TOTAL_C) ||
                      (de_fall && de_len_q != H_ACTIVE_C);
  assign frame_good = !(frame_bad_q || bad_now) &&
                      v_lines_eff == V_TOTAL_C && de_lines_eff == V_ACTIVE_C;

  always_comb begin
    x_cnt_d = x_cnt_q;
    if (de_rise)                         x_cnt_d = '0;
    else if (de_q && x_cnt_q != 10'h3FF) x_cnt_d = x_cnt_q + 10'd1;
    y_cnt_d = y_cnt_q;
    if (vs_fall)                           y_cnt_d = '0;
    else if (de_fall && y_cnt_q != 10'h3FF) y_cnt_d = y_cnt_q + 10'd1;
    h_per_d = h_per_q;
    if (hs_fall)                 h_per_d = '0;
    else if (h_per_q != 11'h7FF) h_per_d = h_per_q + 11'd1;
    de_len_d = de_len_q;
    if (de_rise)                          de_len_d = 11'd1;
    else if (de_q && de_len_q != 11'h7FF) de_len_d = de_len_q + 11'd1;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    if (tmo) begin
      state_d    = S_SEARCH;
      good_cnt_d = '0;
      err_d      = 1'b1;
    end else if (vs_fall) begin
      case (state_q)
        S_SEARCH: begin
          state_d    = S_CHECK;
          good_cnt_d = '0;
        end
        S_CHECK: begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == LOCK_C) state_d = S_LOCKED;
          end else begin
            good_cnt_d = '0;
          end
        end
        S_LOCKED: begin
          if (!frame_good) begin
            state_d    = S_SEARCH;
            good_cnt_d = '0;
            err_d      = 1'b1;
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0;
      hs_dly_q <= 1'b0; vs_dly_q <= 1'b0; de_dly_q <= 1'b0;
      x_cnt_q <= '0; y_cnt_q <= '0; h_per_q <= '0;
      v_lines_q <= '0; de_len_q <= '0; de_lines_q <= '0;
      frame_bad_q <= 1'b0; tmo_armed_q <= 1'b1;
      state_q <= S_SEARCH; good_cnt_q <= '0;
      x_pixel_q <= '0; y_pixel_q <= '0; pixel_valid_q <= 1'b0; frame_start_q <= 1'b0;
      h_total_meas_q <= '0; v_total_meas_q <= '0; locked_q <= 1'b0; timing_err_q <= 1'b0;
    end else begin
      hs_q <= h_sync; vs_q <= v_sync; de_q <= DE;
      hs_dly_q <= hs_q; vs_dly_q <= vs_q; de_dly_q <= de_q;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      h_per_q  <= h_per_d;
      de_len_q <= de_len_d;
      if (hs_fall) h_total_meas_q <= h_meas;
      if (vs_fall) begin
        v_total_meas_q <= v_lines_eff;
        v_lines_q      <= '0;
        de_lines_q     <= '0;
        frame_bad_q    <= 1'b0;
      end else begin
        v_lines_q   <= v_lines_eff;
        de_lines_q  <= de_lines_eff;
        frame_bad_q <= frame_bad_q | bad_now;
      end
      if (hs_fall)  tmo_armed_q <= 1'b1;
      else if (tmo) tmo_armed_q <= 1'b0;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      // Coordinates land together with pixel_valid, two clocks after DE
      x_pixel_q      <= de_q ? x_cnt_d : x_pixel_q;
      y_pixel_q      <= de_q ? y_cnt_q : y_pixel_q;
      pixel_valid_q  <= de_q;
      frame_start_q  <= vs_fall;
      locked_q       <= (state_d == S_LOCKED);
      timing_err_q   <= err_d;
    end
  end

  assign x_pixel      = x_pixel_q;
  assign y_pixel      = y_pixel_q;
  assign pixel_valid  = pixel_valid_q;
  assign frame_start  = frame_start_q;
  assign h_total_meas = h_total_meas_q;
  assign v_total_meas = v_total_meas_q;
  assign locked       = locked_q;
  assign timing_err   = timing_err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a scaled-down raster
// (8x4 visible, 12x6 total) so that many frames fit in a short run.
module tb_vga_sync_receiver;

  localparam int H_A  = 8;
  localparam int H_T  = 12;
  localparam int V_A  = 4;
  localparam int V_T  = 6;
  localparam int HS_B = 9;
  localparam int HS_E = 11;
  localparam int VS_L = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        h_sync = 1'b1, v_sync = 1'b1, DE = 1'b0;
  logic [9:0]  x_pixel, y_pixel, v_total_meas;
  logic [10:0] h_total_meas;
  logic        pixel_valid, frame_start, locked, timing_err;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_ACTIVE(H_A), .H_TOTAL(H_T), .V_ACTIVE(V_A), .V_TOTAL(V_T), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .h_sync(h_sync), .v_sync(v_sync), .DE(DE),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .h_total_meas(h_total_meas),
    .v_total_meas(v_total_meas), .locked(locked), .timing_err(timing_err)
  );

  int   n_checks = 0, n_err = 0;
  int   err_seen = 0, vld_cnt = 0;
  int   first_x = -1, first_y = -1, last_x = -1, last_y = -1;
  bit   got_first = 1'b0, chk_pix = 1'b0;
  logic prev_vs = 1'b1;
  logic pipe_de [2] = '{1'b0, 1'b0};
  logic pipe_fs [2] = '{1'b0, 1'b0};
  int   pipe_x  [2] = '{0, 0};
  int   pipe_y  [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observe outputs at the negedge, then drive the next input vector
  task automatic step(input logic hs, input logic vs, input logic de, input int x, input int y);
    @(negedge clk);
    if (timing_err === 1'b1) err_seen++;
    if (pixel_valid === 1'b1) begin
      vld_cnt++;
      if (!got_first) begin
        first_x = int'(x_pixel); first_y = int'(y_pixel); got_first = 1'b1;
      end
      last_x = int'(x_pixel); last_y = int'(y_pixel);
    end
    if (chk_pix) begin
      check("pixel_valid", pixel_valid, pipe_de[1]);
      check("frame_start", frame_start, pipe_fs[1]);
      if (pipe_de[1]) begin
        check("x_pixel", x_pixel, pipe_x[1]);
        check("y_pixel", y_pixel, pipe_y[1]);
      end
    end
    pipe_de[1] = pipe_de[0]; pipe_fs[1] = pipe_fs[0];
    pipe_x[1]  = pipe_x[0];  pipe_y[1]  = pipe_y[0];
    pipe_de[0] = de; pipe_fs[0] = prev_vs & ~vs;
    pipe_x[0]  = x;  pipe_y[0]  = y;
    prev_vs = vs;
    h_sync = hs; v_sync = vs; DE = de;
  endtask

  task automatic frame(input int nlines, input int nde, input int short_line, input int abort_line);
    int len;
    for (int l = 0; l < nlines; l++) begin
      if (l == abort_line) begin
        @(negedge clk);
        reset_n = 1'b0; h_sync = 1'b1; v_sync = 1'b1; DE = 1'b0; prev_vs = 1'b1;
        return;
      end
      len = (l == short_line) ? H_T - 1 : H_T;
      for (int p = 0; p < len; p++)
        step(!(p >= HS_B && p < HS_E), !(l == VS_L), (l < nde && p < H_A), p, l);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_valid"},  pixel_valid, 0);
    check({tag, "_fstart"}, frame_start, 0);
    check({tag, "_err"},    timing_err, 0);
    check({tag, "_hmeas"},  h_total_meas, 0);
    check({tag, "_vmeas"},  v_total_meas, 0);
    check({tag, "_x"},      x_pixel, 0);
    check({tag, "_y"},      y_pixel, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    @(negedge clk); reset_n = 1'b1;

    // Acquire lock on standard timing
    frame(6, 4, -1, -1);
    check("lock_f1", locked, 0);
    check("vmeas_partial", v_total_meas, 4);
    frame(6, 4, -1, -1);
    check("lock_f2", locked, 0);
    frame(6, 4, -1, -1);
    check("lock_f3", locked, 1);
    check("hmeas", h_total_meas, H_T);
    check("vmeas", v_total_meas, V_T);

    // Pixel coordinates on a locked stream
    vld_cnt = 0; got_first = 1'b0; chk_pix = 1'b1;
    frame(6, 4, -1, -1);
    chk_pix = 1'b0;
    check("vld_count", vld_cnt, H_A * V_A);
    check("first_x", first_x, 0);
    check("first_y", first_y, 0);
    check("last_x", last_x, H_A - 1);
    check("last_y", last_y, V_A - 1);
    check("still_locked", locked, 1);

    // One short line while locked
    err_seen = 0;
    frame(6, 4, 1, -1);
    check("short_err", err_seen, 1);
    check("short_unlock", locked, 0);
    frame(6, 4, -1, -1);
    frame(6, 4, -1, -1);
    check("relock_2", locked, 0);
    frame(6, 4, -1, -1);
    check("relock_3", locked, 1);
    check("relock_err", err_seen, 1);

    // h_sync stuck high: single timeout error, back to SEARCH
    err_seen = 0;
    idle(40);
    check("tmo_err", err_seen, 1);
    check("tmo_unlock", locked, 0);
    frame(6, 4, -1, -1);
    frame(6, 4, -1, -1);
    check("tmo_search_2", locked, 0);
    frame(6, 4, -1, -1);
    check("tmo_relock", locked, 1);

    // Asynchronous reset mid-frame
    frame(6, 4, -1, 2);
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    frame(6, 4, -1, -1);
    frame(6, 4, -1, -1);
    check("rst_relock_2", locked, 0);
    frame(6, 4, -1, -1);
    check("rst_relock_3", locked, 1);

    // Frame one line short during CHECK clears the good-frame count
    pulse_reset();
    frame(6, 4, -1, -1);
    frame(5, 4, -1, -1);
    frame(6, 4, -1, -1);
    check("vshort_lock", locked, 0);
    check("vshort_vmeas", v_total_meas, V_T - 1);
    frame(6, 4, -1, -1);
    check("vshort_cleared", locked, 0);
    frame(6, 4, -1, -1);
    check("vshort_relock", locked, 1);

    // Frame missing one DE line during CHECK
    pulse_reset();
    frame(6, 4, -1, -1);
    frame(6, 4, -1, -1);
    frame(6, 3, -1, -1);
    check("deshort_lock", locked, 0);
    frame(6, 4, -1, -1);
    check("deshort_cleared", locked, 0);
    frame(6, 4, -1, -1);
    check("deshort_relock", locked, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
